// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: rebuilds the value shown by a 6-digit multiplexed
// common-anode seven-segment driver by sampling its scan outputs.
module seg_scan_decoder #(
    parameter int STABLE_CYC = 16,
    parameter int BLANK_CYC  = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  seg_sel,
    input  logic [7:0]  seg_led,
    output logic [19:0] data,
    output logic [5:0]  point,
    output logic        sign,
    output logic        valid,
    output logic        err,
    output logic        disp_on
);
    localparam int SW = $clog2(STABLE_CYC + 1);
    localparam int BW = $clog2(BLANK_CYC + 1);
    localparam logic [3:0] D_BLANK = 4'd10;
    localparam logic [3:0] D_MINUS = 4'd11;

    typedef enum logic [1:0] {COLLECT, CONV, DONE} state_t;
    state_t state, state_nxt;

    logic [5:0]    sel_q, sel_p;
    logic [7:0]    led_q, led_p;
    logic [SW-1:0] stab_cnt;
    logic [BW-1:0] blank_cnt;
    logic          same, one_low, cap, bad, blank_hit, take;
    logic [2:0]    cap_idx;
    logic [3:0]    code;

    logic [3:0] slot [6];
    logic [3:0] slot_nxt [6];
    logic [5:0] dot, dot_nxt;
    logic [5:0] bmap, bmap_nxt;
    logic       errf, errf_nxt;
    logic       minus_any;

    logic [3:0]  frame [6];
    logic [5:0]  fdot;
    logic        fsign, ferr;
    logic [2:0]  ptr;
    logic [19:0] acc, acc_nxt;
    logic [3:0]  dval;

    // Returns {invalid, digit}; blank and minus map to codes 10 and 11.
    function automatic logic [4:0] seg_decode(input logic [6:0] c);
        case (c)
            7'h40:   seg_decode = {1'b0, 4'd0};
            7'h79:   seg_decode = {1'b0, 4'd1};
            7'h24:   seg_decode = {1'b0, 4'd2};
            7'h30:   seg_decode = {1'b0, 4'd3};
            7'h19:   seg_decode = {1'b0, 4'd4};
            7'h12:   seg_decode = {1'b0, 4'd5};
            7'h02:   seg_decode = {1'b0, 4'd6};
            7'h78:   seg_decode = {1'b0, 4'd7};
            7'h00:   seg_decode = {1'b0, 4'd8};
            7'h10:   seg_decode = {1'b0, 4'd9};
            7'h7F:   seg_decode = {1'b0, D_BLANK};
            7'h3F:   seg_decode = {1'b0, D_MINUS};
            default: seg_decode = {1'b1, D_BLANK};
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q <= '1;
            led_q <= '1;
            sel_p <= '1;
            led_p <= '1;
        end else begin
            sel_q <= seg_sel;
            led_q <= seg_led;
            sel_p <= sel_q;
            led_p <= led_q;
        end
    end

    assign same = ({sel_q, led_q} == {sel_p, led_p});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stab_cnt <= '0;
        end else if (!same) begin
            stab_cnt <= '0;
        end else if (stab_cnt != SW'(STABLE_CYC)) begin
            stab_cnt <= stab_cnt + 1'b1;
        end
    end

    always_comb begin
        cap_idx = 3'd0;
        for (int i = 0; i < 6; i++) begin
            if (!sel_q[i]) cap_idx = 3'(i);
        end
    end

    assign one_low     = $onehot(~sel_q);
    assign cap         = same && one_low && (stab_cnt == SW'(STABLE_CYC - 1));
    assign {bad, code} = seg_decode(led_q[6:0]);

    always_comb begin
        for (int i = 0; i < 6; i++) slot_nxt[i] = slot[i];
        dot_nxt  = dot;
        bmap_nxt = bmap;
        errf_nxt = errf;
        if (cap) begin
            slot_nxt[cap_idx] = code;
            dot_nxt[cap_idx]  = ~led_q[7];
            bmap_nxt[cap_idx] = 1'b1;
            errf_nxt          = errf | bad;
        end
    end

    always_comb begin
        minus_any = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (slot_nxt[i] == D_MINUS) minus_any = 1'b1;
        end
    end

    // A full bitmap seen while converting stays full until DONE picks it up.
    assign take = (bmap_nxt == 6'h3F) && (state == COLLECT || state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot <= '{default: 4'd0};
            dot  <= '0;
            bmap <= '0;
            errf <= 1'b0;
        end else begin
            slot <= slot_nxt;
            dot  <= dot_nxt;
            if (blank_hit || take) begin
                bmap <= '0;
                errf <= 1'b0;
            end else begin
                bmap <= bmap_nxt;
                errf <= errf_nxt;
            end
        end
    end

    assign blank_hit = (sel_q == 6'h3F) && (blank_cnt == BW'(BLANK_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blank_cnt <= '0;
            disp_on   <= 1'b0;
        end else begin
            if (sel_q != 6'h3F) begin
                blank_cnt <= '0;
            end else if (blank_cnt != BW'(BLANK_CYC)) begin
                blank_cnt <= blank_cnt + 1'b1;
            end
            if (blank_hit) begin
                disp_on <= 1'b0;
            end else if (cap) begin
                disp_on <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= COLLECT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            COLLECT: if (take) state_nxt = CONV;
            CONV:    if (ptr == 3'd0) state_nxt = DONE;
            DONE:    state_nxt = take ? CONV : COLLECT;
            default: state_nxt = COLLECT;
        endcase
    end

    always_comb begin
        valid = (state == DONE) && !ferr;
        err   = (state == DONE) && ferr;
    end

    assign dval    = (frame[ptr] < 4'd10) ? frame[ptr] : 4'd0;
    assign acc_nxt = (acc << 3) + (acc << 1) + {16'd0, dval};

    // Results land on the last CONV edge so they are stable while DONE pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame <= '{default: 4'd0};
            fdot  <= '0;
            fsign <= 1'b0;
            ferr  <= 1'b0;
            ptr   <= 3'd0;
            acc   <= '0;
            data  <= '0;
            point <= '0;
            sign  <= 1'b0;
        end else if (take) begin
            frame <= slot_nxt;
            fdot  <= dot_nxt;
            fsign <= minus_any;
            ferr  <= errf_nxt;
            ptr   <= 3'd5;
            acc   <= '0;
        end else if (state == CONV) begin
            acc <= acc_nxt;
            ptr <= ptr - 1'b1;
            if (ptr == 3'd0 && !ferr) begin
                data  <= acc_nxt;
                point <= fdot;
                sign  <= fsign;
            end
        end
    end
endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder: directed scans plus randomized frames
// checked against a digit-table reference model.
module tb_seg_scan_decoder;
    localparam int STABLE = 16;
    localparam int BLANK  = 1000;
    localparam int LAT    = STABLE + 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  seg_sel = 6'h3F;
    logic [7:0]  seg_led = 8'hFF;
    logic [19:0] data;
    logic [5:0]  point;
    logic        sign, valid, err, disp_on;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int vcnt = 0;
    int ecnt = 0;
    int v_cyc = 0;
    logic [19:0] v_data = '0;
    logic [5:0]  v_point = '0;
    logic        v_sign = 1'b0;
    int last_val = 0;

    logic [7:0] fr [6];
    logic [6:0] tab [12] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
                             7'h02, 7'h78, 7'h00, 7'h10, 7'h7F, 7'h3F};

    seg_scan_decoder #(.STABLE_CYC(STABLE), .BLANK_CYC(BLANK)) dut (
        .clk(clk), .rst_n(rst_n), .seg_sel(seg_sel), .seg_led(seg_led),
        .data(data), .point(point), .sign(sign), .valid(valid),
        .err(err), .disp_on(disp_on)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (valid) begin
            vcnt++;
            v_data = data;
            v_point = point;
            v_sign = sign;
            v_cyc = cyc;
        end
        if (err) ecnt++;
    end

    function automatic void model(output int val, output logic [5:0] pt,
                                  output logic sg, output logic bd);
        int p;
        int k;
        p = 1; val = 0; pt = '0; sg = 1'b0; bd = 1'b0;
        for (int n = 0; n < 6; n++) begin
            k = -1;
            for (int j = 0; j < 12; j++) if (fr[n][6:0] == tab[j]) k = j;
            if (k < 0) bd = 1'b1;
            else if (k < 10) val += k * p;
            else if (k == 11) sg = 1'b1;
            pt[n] = ~fr[n][7];
            p *= 10;
        end
    endfunction

    task automatic drive(input int n, input logic [7:0] c, input int dwell);
        seg_sel = ~(6'd1 << n[2:0]);
        seg_led = c;
        repeat (dwell) @(posedge clk);
        #1;
    endtask

    task automatic scan_frame(input int dwell);
        for (int n = 0; n < 6; n++) drive(n, fr[n], dwell);
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (data !== 20'd0) begin n_bad++; $display("FAIL rst_data got %0d want 0", data); end
        n_cmp++; if (point !== 6'd0) begin n_bad++; $display("FAIL rst_point got %b want 0", point); end
        n_cmp++; if ({sign, valid, err, disp_on} !== 4'b0) begin n_bad++; $display("FAIL rst_flags got %b want 0000", {sign, valid, err, disp_on}); end
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if ({valid, err, disp_on} !== 3'b0) begin n_bad++; $display("FAIL post_rst got %b want 000", {valid, err, disp_on}); end
    endtask

    task automatic test_123456;
        int v0, t;
        fr = '{8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9};
        v0 = vcnt;
        for (int n = 0; n < 5; n++) drive(n, fr[n], 50);
        t = cyc;
        drive(5, fr[5], 50);
        n_cmp++; if (vcnt !== v0 + 1) begin n_bad++; $display("FAIL n123456_valid got %0d want %0d", vcnt - v0, 1); end
        n_cmp++; if (v_cyc - t !== LAT) begin n_bad++; $display("FAIL n123456_latency got %0d want %0d", v_cyc - t, LAT); end
        n_cmp++; if (v_data !== 20'd123456) begin n_bad++; $display("FAIL n123456_data got %0d want 123456", v_data); end
        n_cmp++; if ({v_sign, v_point} !== 7'd0) begin n_bad++; $display("FAIL n123456_pt_sign got %b want 0", {v_sign, v_point}); end
        n_cmp++; if (disp_on !== 1'b1) begin n_bad++; $display("FAIL n123456_disp_on got %b want 1", disp_on); end
    endtask

    task automatic test_minus42;
        int v0;
        fr = '{8'hA4, 8'h19, 8'hBF, 8'hFF, 8'hFF, 8'hFF};
        v0 = vcnt;
        scan_frame(40);
        n_cmp++; if (vcnt !== v0 + 1) begin n_bad++; $display("FAIL m42_valid got %0d want 1", vcnt - v0); end
        n_cmp++; if (v_data !== 20'd42) begin n_bad++; $display("FAIL m42_data got %0d want 42", v_data); end
        n_cmp++; if (v_sign !== 1'b1) begin n_bad++; $display("FAIL m42_sign got %b want 1", v_sign); end
        n_cmp++; if (v_point !== 6'b000010) begin n_bad++; $display("FAIL m42_point got %b want 000010", v_point); end
    endtask

    task automatic test_error;
        int v0, e0;
        fr = '{8'hF8, 8'hC0, 8'hC0, 8'hAA, 8'hC0, 8'hC0};
        v0 = vcnt; e0 = ecnt;
        scan_frame(40);
        n_cmp++; if (ecnt !== e0 + 1) begin n_bad++; $display("FAIL err_pulse got %0d want 1", ecnt - e0); end
        n_cmp++; if (vcnt !== v0) begin n_bad++; $display("FAIL err_novalid got %0d want 0", vcnt - v0); end
        n_cmp++; if (data !== 20'd42) begin n_bad++; $display("FAIL err_hold got %0d want 42", data); end
        fr[3] = 8'hC0;
        scan_frame(40);
        n_cmp++; if (vcnt !== v0 + 1 || ecnt !== e0 + 1) begin n_bad++; $display("FAIL err_recover got v%0d e%0d want v1 e1", vcnt - v0, ecnt - e0); end
        n_cmp++; if (v_data !== 20'd7) begin n_bad++; $display("FAIL err_next_data got %0d want 7", v_data); end
    endtask

    task automatic test_glitch;
        int v0;
        fr = '{8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0};
        v0 = vcnt;
        drive(0, fr[0], 30);
        drive(1, fr[1], 30);
        drive(2, 8'h90, 10);
        for (int n = 3; n < 6; n++) drive(n, fr[n], 30);
        n_cmp++; if (vcnt !== v0) begin n_bad++; $display("FAIL glitch_novalid got %0d want 0", vcnt - v0); end
        drive(2, fr[2], 40);
        n_cmp++; if (vcnt !== v0 + 1) begin n_bad++; $display("FAIL glitch_valid got %0d want 1", vcnt - v0); end
        n_cmp++; if (v_data !== 20'd12345) begin n_bad++; $display("FAIL glitch_data got %0d want 12345", v_data); end
    endtask

    task automatic test_random;
        int v0, e0, dwell, g, k, ev;
        logic [5:0] ep;
        logic es, eb, dp;
        for (int f = 0; f < 10; f++) begin
            for (int n = 0; n < 6; n++) begin
                k = $urandom_range(0, 11);
                dp = 1'($urandom_range(0, 1));
                fr[n] = {~dp, tab[k]};
            end
            model(ev, ep, es, eb);
            dwell = $urandom_range(30, 60);
            g = $urandom_range(0, 7);
            v0 = vcnt; e0 = ecnt;
            for (int n = 0; n < 6; n++) begin
                if (n == g) drive(n, 8'($urandom), $urandom_range(2, STABLE - 4));
                drive(n, fr[n], dwell);
            end
            n_cmp++; if (vcnt !== v0 + 1 || ecnt !== e0) begin n_bad++; $display("FAIL rnd%0d_pulses got v%0d e%0d want v1 e0", f, vcnt - v0, ecnt - e0); end
            n_cmp++; if (v_data !== 20'(ev)) begin n_bad++; $display("FAIL rnd%0d_data got %0d want %0d", f, v_data, ev); end
            n_cmp++; if ({v_sign, v_point} !== {es, ep}) begin n_bad++; $display("FAIL rnd%0d_pt_sign got %b want %b", f, {v_sign, v_point}, {es, ep}); end
            last_val = ev;
        end
    endtask

    task automatic test_blank;
        int v0;
        seg_sel = 6'h3F;
        seg_led = 8'hFF;
        repeat (BLANK) @(posedge clk);
        #1;
        n_cmp++; if (disp_on !== 1'b1) begin n_bad++; $display("FAIL blank_early got %b want 1", disp_on); end
        @(posedge clk);
        #1;
        n_cmp++; if (disp_on !== 1'b0) begin n_bad++; $display("FAIL blank_off got %b want 0", disp_on); end
        n_cmp++; if (data !== 20'(last_val)) begin n_bad++; $display("FAIL blank_hold got %0d want %0d", data, last_val); end
        fr = '{default: 8'h90};
        v0 = vcnt;
        drive(0, fr[0], 30);
        n_cmp++; if (disp_on !== 1'b1) begin n_bad++; $display("FAIL blank_resume got %b want 1", disp_on); end
        for (int n = 1; n < 6; n++) drive(n, fr[n], 40);
        n_cmp++; if (vcnt !== v0 + 1) begin n_bad++; $display("FAIL n999999_valid got %0d want 1", vcnt - v0); end
        n_cmp++; if (v_data !== 20'd999999) begin n_bad++; $display("FAIL n999999_data got %0d want 999999", v_data); end
    endtask

    task automatic test_reset_conv;
        int v0, e0;
        fr = '{8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82};
        v0 = vcnt; e0 = ecnt;
        for (int n = 0; n < 5; n++) drive(n, fr[n], 30);
        drive(5, fr[5], STABLE + 3);
        rst_n = 1'b0;
        #1;
        n_cmp++; if (data !== 20'd0 || point !== 6'd0) begin n_bad++; $display("FAIL rconv_data got %0d/%b want 0/0", data, point); end
        n_cmp++; if ({sign, valid, err, disp_on} !== 4'b0) begin n_bad++; $display("FAIL rconv_flags got %b want 0000", {sign, valid, err, disp_on}); end
        seg_sel = 6'h3F;
        seg_led = 8'hFF;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        n_cmp++; if (vcnt !== v0 || ecnt !== e0) begin n_bad++; $display("FAIL rconv_nopulse got v%0d e%0d want 0 0", vcnt - v0, ecnt - e0); end
        scan_frame(40);
        n_cmp++; if (vcnt !== v0 + 1) begin n_bad++; $display("FAIL rconv_valid got %0d want 1", vcnt - v0); end
        n_cmp++; if (v_data !== 20'd654321) begin n_bad++; $display("FAIL rconv_data_after got %0d want 654321", v_data); end
    endtask

    initial begin
        test_reset();
        test_123456();
        test_minus42();
        test_error();
        test_glitch();
        test_random();
        test_blank();
        test_reset_conv();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
